// File: rtl/keccak_pkg.sv
// Shared constants, slice bit indexing and FSM encoding for the slice-serial chi engine.
// Latency: none (declarations only).
// Backpressure: none.
package keccak_pkg;

    localparam int SLICE_W = 25;
    localparam int ROW_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chiState_e;

    // Bit position of lane (x,y) inside one 25-bit slice.
    function automatic int sliceIdx(input int x, input int y);
        return ROW_W * y + x;
    endfunction

endpackage

// File: rtl/chi_slice.sv
// Chi (plus optional iota bit) on one 25-bit Keccak slice.
// Latency: purely combinational.
// Backpressure: none.
module chi_slice
    import keccak_pkg::*;
(
    input  logic [SLICE_W-1:0] in,
    input  logic               rcBit,
    input  logic               iotaEn,
    output logic [SLICE_W-1:0] out
);

    always_comb begin
        out = '0;
        for (int y = 0; y < ROW_W; y++) begin
            for (int x = 0; x < ROW_W; x++) begin
                out[sliceIdx(x, y)] = in[sliceIdx(x, y)]
                    ^ (~in[sliceIdx((x + 1) % ROW_W, y)] & in[sliceIdx((x + 2) % ROW_W, y)]);
            end
        end
        if (iotaEn) begin
            out[0] = out[0] ^ rcBit;
        end
    end

endmodule

// File: rtl/keccak_chi_serial.sv
// In-place slice-serial Keccak chi/iota over a 25*LANE_W state, SLICES_PER_CYC slices per clock.
// Latency: done pulses LANE_W/SLICES_PER_CYC cycles after the accepting edge.
// Backpressure: start is ignored while busy; result held until the next accepted start.
module keccak_chi_serial
    import keccak_pkg::*;
#(
    parameter int LANE_W         = 64,
    parameter int SLICES_PER_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SLICE_W*LANE_W-1:0] in,
    input  logic                      iotaEn,
    input  logic [LANE_W-1:0]         rc,
    output logic                      busy,
    output logic                      done,
    output logic [SLICE_W*LANE_W-1:0] out
);

    localparam int N     = LANE_W / SLICES_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int GRP_W = SLICE_W * SLICES_PER_CYC;

    chiState_e                 state;
    chiState_e                 stateNxt;
    logic [CNT_W-1:0]          cnt;
    logic [SLICE_W*LANE_W-1:0] stateReg;
    logic                      iotaEnQ;
    logic [LANE_W-1:0]         rcQ;
    logic [GRP_W-1:0]          grpIn;
    logic [GRP_W-1:0]          grpOut;
    logic [SLICES_PER_CYC-1:0] grpRc;
    logic [N-1:0]              grpEn;
    logic                      accept;
    logic                      lastCnt;

    assign accept  = start && (state != RUN);
    assign lastCnt = (cnt == CNT_W'(N - 1));
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign out     = stateReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = RUN;
            RUN:     if (lastCnt) stateNxt = DONE;
            DONE:    stateNxt = start ? RUN : IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Group read mux and per-group write enables, both addressed by cnt.
    always_comb begin
        grpIn = '0;
        grpRc = '0;
        grpEn = '0;
        for (int g = 0; g < N; g++) begin
            if (cnt == CNT_W'(g)) begin
                grpIn    = stateReg[g*GRP_W +: GRP_W];
                grpRc    = rcQ[g*SLICES_PER_CYC +: SLICES_PER_CYC];
                grpEn[g] = (state == RUN);
            end
        end
    end

    for (genvar s = 0; s < SLICES_PER_CYC; s++) begin : gSlice
        chi_slice uChi (
            .in     (grpIn[s*SLICE_W +: SLICE_W]),
            .rcBit  (grpRc[s]),
            .iotaEn (iotaEnQ),
            .out    (grpOut[s*SLICE_W +: SLICE_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= '0;
            iotaEnQ  <= 1'b0;
            rcQ      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            stateReg <= in;
            iotaEnQ  <= iotaEn;
            rcQ      <= rc;
            cnt      <= '0;
        end else if (state == RUN) begin
            for (int g = 0; g < N; g++) begin
                if (grpEn[g]) begin
                    stateReg[g*GRP_W +: GRP_W] <= grpOut;
                end
            end
            if (!lastCnt) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_chi_serial.sv
// Bench for keccak_chi_serial: three configurations checked against a lane-wise chi/iota model.
module tb_keccak_chi_serial;

    localparam int LW = 64;
    localparam int SW = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic          start, iotaEn, busy, done;
    logic [SW-1:0] inS, outS;
    logic [63:0]   rc;

    logic          wStart, wIe, wBusy, wDone;
    logic [SW-1:0] wIn, wOut;
    logic [63:0]   wRc;

    logic          sStart, sIe, sBusy, sDone;
    logic [199:0]  sIn, sOut;
    logic [7:0]    sRc;

    int vecs = 0;
    int errs = 0;

    keccak_chi_serial #(.LANE_W(64), .SLICES_PER_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in(inS), .iotaEn(iotaEn), .rc(rc),
        .busy(busy), .done(done), .out(outS)
    );

    keccak_chi_serial #(.LANE_W(64), .SLICES_PER_CYC(64)) dutWide (
        .clk(clk), .rst(rst), .start(wStart), .in(wIn), .iotaEn(wIe), .rc(wRc),
        .busy(wBusy), .done(wDone), .out(wOut)
    );

    keccak_chi_serial #(.LANE_W(8), .SLICES_PER_CYC(2)) dutSmall (
        .clk(clk), .rst(rst), .start(sStart), .in(sIn), .iotaEn(sIe), .rc(sRc),
        .busy(sBusy), .done(sDone), .out(sOut)
    );

    // Lane-oriented reference: whole 64-bit lanes combined at once, then scattered back to slices.
    function automatic logic [SW-1:0] chiModel(input logic [SW-1:0] s, input logic ie,
                                               input logic [63:0] r, input int lanes);
        logic [63:0]   a [5][5];
        logic [63:0]   b [5][5];
        logic [SW-1:0] o;
        o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                a[x][y] = '0;
                for (int z = 0; z < lanes; z++) a[x][y][z] = s[25*z + 5*y + x];
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[x][y] = a[x][y] ^ (~a[(x+1)%5][y] & a[(x+2)%5][y]);
        if (ie) b[0][0] = b[0][0] ^ r;
        for (int z = 0; z < lanes; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) o[25*z + 5*y + x] = b[x][y][z];
        return o;
    endfunction

    function automatic logic [SW-1:0] randState();
        logic [SW-1:0] r;
        for (int i = 0; i < SW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Protocol model for the main instance: run length, done pulse and held result.
    int            mLeft = 0;
    bit            mDone = 1'b0;
    logic [SW-1:0] mOut  = '0;
    logic [SW-1:0] mPend = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mLeft = 0;
            mDone = 1'b0;
            mOut  = '0;
        end else if (mLeft > 0) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mDone = 1'b1;
                mOut  = mPend;
            end
        end else begin
            mDone = 1'b0;
            if (start) begin
                mLeft = LW;
                mPend = chiModel(inS, iotaEn, rc, LW);
            end
        end
    end

    always @(negedge clk) begin
        vecs++;
        if (busy !== (mLeft > 0) || done !== mDone || (mLeft == 0 && outS !== mOut)) begin
            errs++;
            $display("FAIL cycle t=%0t: busy=%0b want %0b, done=%0b want %0b, outMatch=%0b",
                     $time, busy, (mLeft > 0), done, mDone, (outS === mOut));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkState(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        int bad;
        vecs++;
        if (act !== exp) begin
            errs++;
            bad = 0;
            for (int z = 63; z >= 0; z--) if (act[25*z +: 25] !== exp[25*z +: 25]) bad = z;
            $display("FAIL %s: slice %0d got %07h want %07h", name, bad,
                     act[25*bad +: 25], exp[25*bad +: 25]);
        end
    endtask

    task automatic pulseStart(input logic [SW-1:0] v, input logic ie, input logic [63:0] r);
        @(negedge clk);
        inS = v; iotaEn = ie; rc = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until the selected done is seen; gives up at 200.
    task automatic waitSig(input int which, output int k);
        logic d;
        k = 0;
        while (k < 200) begin
            d = (which == 0) ? done : (which == 1) ? wDone : sDone;
            if (d === 1'b1) break;
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int            k, nDone;
        logic [SW-1:0] v, e;
        logic [63:0]   r;

        start = 0; iotaEn = 0; rc = '0; inS = '0;
        wStart = 0; wIe = 0; wRc = '0; wIn = '0;
        sStart = 0; sIe = 0; sRc = '0; sIn = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chkState("rst_out", outS, '0);
        rst = 1'b1;

        // Asynchronous reset in the middle of a run.
        pulseStart({SW{1'b1}}, 1'b0, '0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chkState("midrst_out", outS, '0);
        @(negedge clk);
        rst = 1'b1;
        nDone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) nDone++;
        end
        chk("midrst_no_done", nDone, 0);

        pulseStart('0, 1'b0, '0);
        waitSig(0, k);
        chk("zero_latency", k, 64);
        chkState("zero_out", outS, '0);

        v = '0; v[125] = 1'b1;
        e = '0; e[125 +: 25] = 25'h0000009;
        chkState("model_single_bit", chiModel(v, 1'b0, '0, 64), e);
        pulseStart(v, 1'b0, '0);
        waitSig(0, k);
        chk("bit_latency", k, 64);
        chk("bit_slice5", outS[125 +: 25], 25'h0000009);
        chkState("bit_all", outS, e);

        chkState("model_ones", chiModel({SW{1'b1}}, 1'b0, '0, 64), {SW{1'b1}});
        pulseStart({SW{1'b1}}, 1'b0, '0);
        waitSig(0, k);
        chkState("ones_out", outS, {SW{1'b1}});

        r = 64'h8000000000008082;
        e = '0;
        for (int z = 0; z < 64; z++) e[25*z] = r[z];
        chkState("model_iota", chiModel('0, 1'b1, r, 64), e);
        pulseStart('0, 1'b1, r);
        waitSig(0, k);
        chkState("iota_out", outS, e);

        // start held through RUN with changing inputs: only the first capture counts.
        v = randState();
        @(negedge clk);
        inS = v; iotaEn = 1'b0; rc = '0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            inS = randState(); iotaEn = 1'b1; rc = {$urandom, $urandom};
        end
        start = 1'b0;
        waitSig(0, k);
        chk("hs_done_seen", k < 200, 1);
        chkState("hs_out", outS, chiModel(v, 1'b0, '0, 64));

        // Back-to-back: start during the done cycle restarts without an idle cycle.
        v = randState();
        r = {$urandom, $urandom};
        inS = v; iotaEn = 1'b1; rc = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        waitSig(0, k);
        chk("b2b_latency", k, 64);
        chkState("b2b_out", outS, chiModel(v, 1'b1, r, 64));

        for (int t = 0; t < 3; t++) begin
            v = randState();
            r = {$urandom, $urandom};
            pulseStart(v, t[0], r);
            waitSig(0, k);
            chkState("rand_out", outS, chiModel(v, t[0], r, 64));
        end

        // Fully parallel configuration.
        for (int t = 0; t < 2; t++) begin
            v = randState();
            r = {$urandom, $urandom};
            @(negedge clk);
            wIn = v; wIe = t[0]; wRc = r; wStart = 1'b1;
            @(negedge clk);
            wStart = 1'b0;
            waitSig(1, k);
            chk("wide_latency", k, 1);
            chkState("wide_out", wOut, chiModel(v, t[0], r, 64));
            @(negedge clk);
            chk("wide_done_pulse", wDone, 0);
        end

        // Narrow lanes, two slices per cycle.
        for (int t = 0; t < 2; t++) begin
            v = randState();
            r = '0; r[7:0] = 8'($urandom);
            @(negedge clk);
            sIn = v[199:0]; sIe = ~t[0]; sRc = r[7:0]; sStart = 1'b1;
            @(negedge clk);
            sStart = 1'b0;
            waitSig(2, k);
            chk("small_latency", k, 4);
            e = '0; e[199:0] = v[199:0];
            chkState("small_out", {1400'b0, sOut}, chiModel(e, ~t[0], r, 8));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/keccak_chi_serial.md
Name: keccak_chi_serial

Overview:
- Slice-serial Keccak chi/iota engine over a 25×LANE_W-bit state held in place.
- Captures the state on `start`, then transforms SLICES_PER_CYC slices per clock, writing each result back to its own slice position.
- Signals completion with a one-cycle `done` pulse.
- Generalises the fixed 64-slice, one-slice-per-cycle sequencer:
  - parametrised lane width and parallelism,
  - start/busy/done handshake,
  - optional iota round-constant injection.

Parameters:
- LANE_W, 64, number of slices (Keccak z dimension); power of two in 1..64.
- SLICES_PER_CYC, 1, slices processed per clock; power of two dividing LANE_W.
- Derived: N = LANE_W/SLICES_PER_CYC run cycles; CNT_W = max(1, clog2(N)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin transform; sampled only when not busy.
- in  input  25*LANE_W  input state; slice z = in[25*z +: 25], bit 5*y+x within slice.
- iotaEn  input  1  when 1, XOR rc[z] into bit (x=0,y=0) of slice z after chi.
- rc  input  LANE_W  round constant, bit z applies to slice z.
- busy  output  1  high while a transform is in progress.
- done  output  1  one-cycle pulse when the result is complete.
- out  output  25*LANE_W  state register; valid while done=1 and thereafter until next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, cnt=0, state=0, captured iotaEn/rc=0, busy=0, done=0, out=0. Takes effect mid-run; partial results are discarded.
- FSM states:
  - IDLE: start=1 at edge t0 → load state<=in, latch iotaEn and rc, cnt<=0, go RUN.
  - RUN: at each edge, slices cnt*P .. cnt*P+P-1 (P=SLICES_PER_CYC) are replaced by f(slice); cnt++. The edge where cnt==N-1 writes the final group and goes DONE.
  - DONE: done=1 for exactly one cycle. Next edge: start=1 → same as IDLE accept (back-to-back); else → IDLE.
- busy = (FSM==RUN). start while RUN is ignored, with no effect on state or counter.
- Latency: done is high in the cycle starting at edge t0+N. With P=LANE_W, N=1 and done is high the cycle after the accepting edge.
- Slice function f on bits a[x,y] (x,y in 0..4, index 5y+x):
  - b[x,y] = a[x,y] ^ (~a[(x+1)%5,y] & a[(x+2)%5,y]);
  - then if iotaEn, b[0,0] ^= rc[z].
- Chi reads only the current value of the slice being written; slices are independent, so in-place update is exact.
- in, rc and iotaEn changing during RUN have no effect (captured at accept).
- out is a direct view of the state register.
  - During RUN it holds a mix of processed and unprocessed slices; it is undefined for consumers.
  - After DONE it is held stable until the next accepted start.
- cnt wraps never: the DONE transition occurs at cnt==N-1. cnt resets to 0 on each accept.

Decomposition:
- Package keccak_pkg:
  - SLICE_W=25, ROW_W=5;
  - slice index helper (5*y+x);
  - FSM state encoding (IDLE, RUN, DONE).
- Sub-module chi_slice:
  - combinational, in[24:0], rcBit, iotaEn → out[24:0].
  - Instantiated SLICES_PER_CYC times in a generate loop.
- Top level holds:
  - the FSM and counter;
  - write-back addressed by cnt (decoded group enable per slice group);
  - read via group multiplexer.

Test Plan:
- Reset mid-run: start with in=all ones, assert rst=0 after 10 cycles → busy=0, done=0, out=0 immediately. After release, no done until a new start.
- All-zero: in=0, iotaEn=0, start one cycle → busy high 64 cycles, done pulse exactly 64 cycles after accept edge, out=0.
- Single bit, P=1: in slice 5 = 25'h0000001, others 0 → out slice 5 = 25'h0000009, all other slices 0; all-ones input → all-ones output.
- Iota: in=0, iotaEn=1, rc=64'h8000000000008082 → out bit 25*z = rc[z] for every z, all other bits 0.
- Handshake: assert start continuously with different in values during RUN → only the first is processed. start held during DONE → new run begins next edge; busy re-rises with no IDLE cycle.
- Parametrised: LANE_W=64, SLICES_PER_CYC=64 → done the cycle after accept. LANE_W=8, SLICES_PER_CYC=2 → done after 4 cycles. Random in compared against a bitwise chi model.
